// File: rtl/seq_shift_4bit.sv
// Iterative shifter: one bit position per clock, start/busy/done handshake.
// Left, logical right, arithmetic right and pass-through, amount saturating at WIDTH.
module seq_shift_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       shift_select,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] SEL_LEFT = 2'b00;
    localparam logic [1:0] SEL_LSR  = 2'b01;
    localparam logic [1:0] SEL_ASR  = 2'b10;
    localparam logic [1:0] SEL_PASS = 2'b11;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] work_q,   work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [1:0]       sel_q,    sel_d;

    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    start_cnt;

    // Amounts at or beyond WIDTH behave exactly like WIDTH single-bit steps.
    always_comb begin
        start_cnt = '0;
        if (shift_select != SEL_PASS) begin
            if (in2 >= WIDTH'(WIDTH)) start_cnt = CW'(WIDTH);
            else                      start_cnt = CW'(in2);
        end
    end

    always_comb begin
        shifted = work_q;
        case (sel_q)
            SEL_LEFT: shifted = work_q << 1;
            SEL_LSR:  shifted = work_q >> 1;
            SEL_ASR:  shifted = WIDTH'($signed(work_q) >>> 1);
            default:  shifted = work_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d = in1;
                    sel_d  = shift_select;
                    cnt_d  = start_cnt;
                    if (start_cnt == '0) begin
                        result_d = in1;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = shifted;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
